xadc_mux_scanner: RTL and testbench

Sequencer for the external 16:1 analog multiplexer feeding the XADC auxiliary input. It walks the enabled channels in ascending order, drives `XADC_MUXADDR`, waits a programmable settle time, triggers one conversion, and emits a tagged result per channel. It sits between the AXI-lite register bank (configuration and start) and the XADC wrapper (convst/eoc/data) in `neuromorphic_asic_bridge_top`.

---
 rtl/xadc_scan_pkg.sv | 19 +
 rtl/xadc_mux_scanner_if.sv | 33 +++
 rtl/mask_priority_enc.sv | 23 ++
 rtl/xadc_mux_scanner.sv | 139 +++++++++++++
 tb/tb_xadc_mux_scanner.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadc_scan_pkg.sv
// Shared constants and state encoding for the external-mux XADC scanner.
package xadc_scan_pkg;

  localparam int NUM_CH      = 16;
  localparam int DATA_W      = 12;
  localparam int CH_W        = $clog2(NUM_CH);
  localparam int PTR_W       = CH_W + 1;  // extra bit so "past last channel" is representable
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONVERT,
    ST_WAIT_EOC,
    ST_STORE
  } state_e;

endpackage

// File: rtl/xadc_mux_scanner_if.sv
// Signal bundle between the register bank / XADC wrapper (master) and the scanner (slave).
interface xadc_mux_scanner_if;
  import xadc_scan_pkg::*;

  // No back-pressure anywhere: scan_start is a one-cycle request accepted only while
  // busy is low; convst, res_valid and scan_done are one-cycle strobes the consumer must take.
  logic              scan_start;
  logic              continuous;
  logic [NUM_CH-1:0] ch_mask;
  logic [15:0]       settle_cycles;
  logic              err_clr;
  logic [CH_W-1:0]   XADC_MUXADDR;
  logic              convst;
  logic              adc_eoc;
  logic [15:0]       adc_data;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              scan_done;
  logic              timeout_err;

  modport slave (
    input  scan_start, continuous, ch_mask, settle_cycles, err_clr, adc_eoc, adc_data,
    output XADC_MUXADDR, convst, res_valid, res_ch, res_data, busy, scan_done, timeout_err
  );

  modport master (
    output scan_start, continuous, ch_mask, settle_cycles, err_clr, adc_eoc, adc_data,
    input  XADC_MUXADDR, convst, res_valid, res_ch, res_data, busy, scan_done, timeout_err
  );

endinterface

// File: rtl/mask_priority_enc.sv
// Lowest enabled channel at or above the search pointer; ptr_i >= NUM_CH finds nothing.
module mask_priority_enc
  import xadc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [CH_W-1:0]   idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Descending scan so the lowest qualifying bit is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (PTR_W'(i) >= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/xadc_mux_scanner.sv
// Walks enabled mux channels, settles, triggers one XADC conversion each and emits tagged results.
module xadc_mux_scanner
  import xadc_scan_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                S_AXI_ACLK,
  input  logic                rst,
  xadc_mux_scanner_if.slave   xif,
  output state_e              dbg_state_o
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q;
  logic [15:0]       settle_q;
  logic [15:0]       settle_cnt_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CH_W-1:0]   ch_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [DATA_W-1:0] res_data_q;
  logic              scan_done_q;
  logic              err_q;
  logic              restart_q;

  logic              found;
  logic [CH_W-1:0]   found_idx;
  logic              tmo_hit;
  logic              unused_adc_lsbs;

  mask_priority_enc u_enc (
    .mask_i  (mask_q),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (found_idx)
  );

  // Fires so that timeout_err becomes visible exactly TIMEOUT cycles after convst.
  assign tmo_hit         = (tmo_q == TMO_W'(TIMEOUT - 2));
  assign unused_adc_lsbs = ^xif.adc_data[15-DATA_W:0];

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (xif.scan_start) state_d = ST_SELECT;
      ST_SELECT: begin
        if (restart_q)           state_d = ST_SELECT;
        else if (found)          state_d = ST_SETTLE;
        else if (xif.continuous) state_d = ST_SELECT;
        else                     state_d = ST_IDLE;
      end
      ST_SETTLE:   if (settle_cnt_q <= 16'd1) state_d = ST_CONVERT;
      ST_CONVERT:  state_d = ST_WAIT_EOC;
      ST_WAIT_EOC: begin
        if (xif.adc_eoc)  state_d = ST_STORE;
        else if (tmo_hit) state_d = ST_SELECT;
      end
      ST_STORE:    state_d = ST_SELECT;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xif.convst    = (state_q == ST_CONVERT);
    xif.res_valid = (state_q == ST_STORE);
    xif.busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      mask_q       <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      ptr_q        <= '0;
      ch_q         <= '0;
      tmo_q        <= '0;
      res_ch_q     <= '0;
      res_data_q   <= '0;
      scan_done_q  <= 1'b0;
      err_q        <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (xif.err_clr) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (xif.scan_start) begin
          mask_q    <= xif.ch_mask;
          settle_q  <= xif.settle_cycles;
          ptr_q     <= '0;
          restart_q <= 1'b0;
        end
        ST_SELECT: begin
          // A continuous wrap spends one idle-like cycle before searching again.
          if (restart_q) begin
            restart_q <= 1'b0;
            ptr_q     <= '0;
          end else if (found) begin
            ch_q         <= found_idx;
            settle_cnt_q <= settle_q;
          end else begin
            scan_done_q <= 1'b1;
            restart_q   <= xif.continuous;
            ptr_q       <= '0;
          end
        end
        ST_SETTLE:  if (settle_cnt_q != 16'd0) settle_cnt_q <= settle_cnt_q - 16'd1;
        ST_CONVERT: tmo_q <= '0;
        ST_WAIT_EOC: begin
          if (xif.adc_eoc) begin
            res_data_q <= xif.adc_data[15 -: DATA_W];
            res_ch_q   <= ch_q;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            ptr_q <= PTR_W'(ch_q) + PTR_W'(1);
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_STORE:   ptr_q <= PTR_W'(ch_q) + PTR_W'(1);
        default:    ;
      endcase
    end
  end

  assign xif.XADC_MUXADDR = ch_q;
  assign xif.res_ch       = res_ch_q;
  assign xif.res_data     = res_data_q;
  assign xif.scan_done    = scan_done_q;
  assign xif.timeout_err  = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_xadc_mux_scanner.sv
// Directed bench for xadc_mux_scanner: scan vector table plus timeout, reset and error-clear sequences.
module tb_xadc_mux_scanner;
  import xadc_scan_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  xadc_mux_scanner_if xif ();

  xadc_mux_scanner #(.TIMEOUT(1024)) dut (
    .S_AXI_ACLK  (clk),
    .rst         (rst),
    .xif         (xif.slave),
    .dbg_state_o (dbg_state)
  );

  // ADC side model: per-channel sample values, eoc a fixed number of cycles after convst.
  function automatic logic [15:0] chan_data(input logic [CH_W-1:0] ch);
    case (ch)
      4'd0:    return 16'hABC0;
      4'd2:    return 16'h1230;
      default: return {ch, 12'h000} | {4'h0, ~ch, 8'h3C};
    endcase
  endfunction

  logic model_eoc = 1'b0;
  logic spur_eoc  = 1'b0;
  bit   model_en  = 1'b1;
  int   eoc_delay = 1;
  int   eoc_pend  = 0;

  assign xif.adc_eoc  = model_eoc | spur_eoc;
  assign xif.adc_data = chan_data(xif.XADC_MUXADDR);

  always @(negedge clk) begin
    model_eoc = 1'b0;
    if (eoc_pend > 0) begin
      eoc_pend--;
      model_eoc = (eoc_pend == 0);
    end
    if (xif.convst && model_en) eoc_pend = eoc_delay;
  end

  // Cycle counter and output monitor.
  int          cyc = 0;
  logic [15:0] got_q[$];
  logic [3:0]  mux_q[$];
  int          done_cnt, convst_cnt, first_convst, first_res;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (xif.res_valid) begin
      got_q.push_back({xif.res_ch, xif.res_data});
      if (first_res < 0) first_res = cyc;
    end
    if (xif.scan_done) done_cnt++;
    if (xif.convst) begin
      convst_cnt++;
      mux_q.push_back(xif.XADC_MUXADDR);
      if (first_convst < 0) first_convst = cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    mux_q.delete();
    done_cnt     = 0;
    convst_cnt   = 0;
    first_convst = -1;
    first_res    = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mux"},      32'(xif.XADC_MUXADDR), 32'd0);
    check({tag, "_res_ch"},   32'(xif.res_ch),       32'd0);
    check({tag, "_res_data"}, 32'(xif.res_data),     32'd0);
    check({tag, "_convst"},   32'(xif.convst),       32'd0);
    check({tag, "_res_vld"},  32'(xif.res_valid),    32'd0);
    check({tag, "_busy"},     32'(xif.busy),         32'd0);
    check({tag, "_done"},     32'(xif.scan_done),    32'd0);
    check({tag, "_terr"},     32'(xif.timeout_err),  32'd0);
    check({tag, "_state"},    32'(dbg_state),        32'(ST_IDLE));
  endtask

  task automatic start_scan(input logic [15:0] mask, input logic [15:0] settle, input bit cont,
                            output int start);
    tick();
    xif.ch_mask       = mask;
    xif.settle_cycles = settle;
    xif.continuous    = cont;
    xif.scan_start    = 1'b1;
    start             = cyc;
    tick();
    xif.scan_start    = 1'b0;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [15:0] settle;
    int          passes;
    int          delay;
    bit          disturb;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] exp_q[$];
    logic [15:0] d;
    logic [3:0]  ch4;
    int          start;
    int          ofs;
    bit          done;
    string       tag;
    tag = $sformatf("v%0d", idx);
    clear_mon();
    model_en  = 1'b1;
    eoc_delay = v.delay;
    for (int p = 0; p < v.passes; p++)
      for (int c = 0; c < NUM_CH; c++)
        if (v.mask[c]) begin
          ch4 = 4'(c);
          d   = chan_data(ch4);
          exp_q.push_back({ch4, d[15:4]});
        end
    start_scan(v.mask, v.settle, v.passes > 1, start);
    check({tag, "_busy_rise"}, 32'(xif.busy), 32'd1);
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (!xif.busy) done = 1'b1;
      else begin
        ofs = cyc - start;
        if (v.disturb) begin
          spur_eoc       = (ofs == 3);
          xif.scan_start = (ofs == 4);
        end
        if (v.passes > 1 && done_cnt >= 1) xif.continuous = 1'b0;
        tick();
      end
    end
    spur_eoc       = 1'b0;
    xif.scan_start = 1'b0;
    check({tag, "_finished"}, 32'(done), 32'd1);
    tick();
    tick();
    check({tag, "_n_res"},    32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_n_done"},   32'(done_cnt),     32'(v.passes));
    check({tag, "_n_convst"}, 32'(convst_cnt),   32'(exp_q.size()));
    check({tag, "_idle"},     32'(dbg_state),    32'(ST_IDLE));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_res%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (i < mux_q.size())
        check($sformatf("%s_mux%0d", tag, i), 32'(mux_q[i]), 32'(exp_q[i][15:12]));
    end
    if (exp_q.size() > 0) begin
      check({tag, "_lat_convst"}, 32'(first_convst - start),
            32'(2 + ((v.settle == 16'd0) ? 1 : int'(v.settle))));
      check({tag, "_lat_res"}, 32'(first_res - first_convst), 32'(v.delay + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int t_conv;
    bit seen;

    vecs[0] = '{mask: 16'h0005, settle: 16'd3, passes: 1, delay: 10, disturb: 1'b0};
    vecs[1] = '{mask: 16'hFFFF, settle: 16'd0, passes: 2, delay: 1,  disturb: 1'b0};
    vecs[2] = '{mask: 16'h0000, settle: 16'd4, passes: 1, delay: 5,  disturb: 1'b0};
    vecs[3] = '{mask: 16'h8001, settle: 16'd1, passes: 1, delay: 1,  disturb: 1'b0};
    vecs[4] = '{mask: 16'h00F0, settle: 16'd2, passes: 1, delay: 3,  disturb: 1'b0};
    vecs[5] = '{mask: 16'h0005, settle: 16'd6, passes: 1, delay: 4,  disturb: 1'b1};
    vecs[6] = '{mask: 16'h4000, settle: 16'd0, passes: 1, delay: 2,  disturb: 1'b0};

    xif.scan_start    = 1'b0;
    xif.continuous    = 1'b0;
    xif.ch_mask       = '0;
    xif.settle_cycles = '0;
    xif.err_clr       = 1'b0;
    clear_mon();

    // Clock/reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Mask 0 single mode: scan_done two cycles after scan_start.
    clear_mon();
    start_scan(16'h0000, 16'd0, 1'b0, start);
    tick();
    check("m0_done_at_2", 32'(xif.scan_done), 32'd1);
    check("m0_done_cyc",  32'(cyc - start),   32'd2);
    tick();
    check("m0_no_convst", 32'(convst_cnt),    32'd0);

    // Timeout: no eoc ever, flag appears 1024 cycles after convst and is sticky.
    clear_mon();
    model_en = 1'b0;
    start_scan(16'h0100, 16'd2, 1'b0, start);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (convst_cnt > 0) seen = 1'b1;
      else tick();
    end
    check("to_convst_seen", 32'(seen), 32'd1);
    t_conv = first_convst;
    seen   = 1'b0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      if (xif.timeout_err) seen = 1'b1;
      else tick();
    end
    check("to_err_seen",  32'(seen),        32'd1);
    check("to_err_delay", 32'(cyc - t_conv), 32'd1024);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (!xif.busy) seen = 1'b1;
      else tick();
    end
    tick();
    check("to_idle",     32'(seen),          32'd1);
    check("to_no_res",   32'(got_q.size()),  32'd0);
    check("to_done",     32'(done_cnt),      32'd1);
    check("to_sticky",   32'(xif.timeout_err), 32'd1);
    xif.err_clr = 1'b1;
    tick();
    xif.err_clr = 1'b0;
    check("to_cleared",  32'(xif.timeout_err), 32'd0);
    model_en = 1'b1;

    // Reset while waiting for eoc: everything back to reset values, late eoc ignored.
    clear_mon();
    eoc_delay = 20;
    start_scan(16'h0002, 16'd1, 1'b0, start);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (convst_cnt > 0) seen = 1'b1;
      else tick();
    end
    check("rw_convst_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    check("rw_in_wait", 32'(dbg_state), 32'(ST_WAIT_EOC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rw");
    repeat (30) tick();
    check("rw_no_res",  32'(got_q.size()), 32'd0);
    check("rw_no_done", 32'(done_cnt),     32'd0);
    check("rw_idle",    32'(dbg_state),    32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
